rr_arbiter_16: RTL and testbench
================================

RR_ARBITER_16 -- requirements
Module: rr_arbiter_16

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum cycles one grant may be held (legal range 2..256).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  arbiter enable; when low, no new grant is issued.
REQ-005 req  input  16  per-requester request lines, level-sensitive, bit i = requester i.
REQ-006 done  input  1  current grantee releases the resource (single-cycle pulse, meaningful only while gnt_valid=1).
REQ-007 gnt  output  16  registered one-hot grant vector.
REQ-008 gnt_idx  output  4  registered binary index of the granted requester.
REQ-009 gnt_valid  output  1  high while a grant is held.
REQ-010 timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-011 The FSM SHALL have two states: IDLE and GRANT.
REQ-012 In IDLE with enable=1 and req!=0, the winner SHALL be the first set req bit found scanning circularly from ptr upward (ptr, ptr+1, ..., 15, 0, ..., ptr-1).
REQ-013 The winner's gnt bit, gnt_idx and gnt_valid=1 SHALL appear on the cycle after the qualifying IDLE cycle (latency 1), and the FSM SHALL enter GRANT.
REQ-014 gnt SHALL always be zero or exactly one-hot.
REQ-015 gnt_idx SHALL always equal the encoded position of the set gnt bit; it SHALL be 0 when gnt=0.
REQ-016 In GRANT, a 16-bit-safe hold counter SHALL increment each cycle, starting at 0 on grant entry.
REQ-017 GRANT SHALL release when any of the following occurs:
  - done=1;
  - req[gnt_idx]=0;
  - hold counter = MAX_HOLD-1 (timeout).
REQ-018 On release, gnt, gnt_idx and gnt_valid SHALL clear on the next edge, the FSM SHALL return to IDLE, and ptr SHALL become gnt_idx+1 modulo 16 (15 wraps to 0).
REQ-019 After each release, the FSM SHALL spend exactly one IDLE cycle (bubble) before any new grant.
REQ-020 timeout SHALL pulse high for one cycle, coincident with the clearing edge, only when the hold limit alone caused the release.
REQ-021 If done or a req drop coincides with the hold limit, the release SHALL be treated as normal and timeout SHALL stay 0.
REQ-022 Deasserting enable during GRANT SHALL NOT revoke the current grant; it SHALL only block the next grant.
REQ-023 ptr SHALL update only on release, never in IDLE.
REQ-024 done asserted while in IDLE SHALL be ignored.

Reset
REQ-025 rst_n low SHALL immediately force: state=IDLE, ptr=0, hold counter=0, gnt=16'h0000, gnt_idx=4'h0, gnt_valid=0, timeout=0.
REQ-026 Reset asserted mid-grant SHALL drop the grant without a timeout pulse.
REQ-027 After reset release, the first grant SHALL follow the REQ-012 scan from ptr=0.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding and the requester count constant (16) with its index width (4).
REQ-029 The one-hot-to-index conversion SHALL be a separate sub-module, onehot_idx16, that is combinational and outputs 0 for a non-one-hot input.
REQ-030 The circular priority scan SHALL be implemented as rotate, fixed-priority select, then rotate back.

Verification
REQ-031 req=16'h0020 held, enable=1 -> one cycle later gnt=16'h0020, gnt_idx=5, gnt_valid=1; done pulse -> cleared next cycle, ptr=6.
REQ-032 req=16'hFFFF held, done pulsed each grant -> gnt_idx sequence 0,1,2,...,15,0, with one-cycle bubbles between grants.
REQ-033 ptr=15 reached, req=16'h8001 -> grant order 15 then 0 (wrap-around).
REQ-034 MAX_HOLD=4, req[3] held, no done -> gnt_valid high exactly 4 cycles, timeout pulses once, ptr=4.
REQ-035 rst_n pulsed low mid-grant -> outputs clear asynchronously, timeout=0; after release, req=16'h0300 -> gnt_idx=8.
REQ-036 enable=0 during grant of idx 2, then done -> no further grant while enable=0 even with req!=0; enable=1 -> next grant found by scanning from ptr=3.

Source files
------------

// File: rtl/rr_arbiter_16_pkg.sv
// Shared types and constants for the 16-way round-robin arbiter.
package rr_arbiter_16_pkg;

  localparam int unsigned NumReq = 16;
  localparam int unsigned IdxW   = 4;
  localparam int unsigned HoldW  = 16;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [NumReq-1:0] v);
    return (v != '0) && ((v & (v - NumReq'(1))) == '0);
  endfunction

endpackage

// File: rtl/rr_arbiter_16_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter_16_if;
  import rr_arbiter_16_pkg::*;

  logic              enable;
  logic [NumReq-1:0] req;
  logic              done;
  logic [NumReq-1:0] gnt;
  logic [IdxW-1:0]   gnt_idx;
  logic              gnt_valid;
  logic              timeout;

  modport master (
    output enable, req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  enable, req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );

endinterface

// File: rtl/onehot_idx16.sv
// Combinational one-hot to binary encoder; any non-one-hot input encodes to 0.
module onehot_idx16
  import rr_arbiter_16_pkg::*;
(
  input  logic [NumReq-1:0] onehot_i,
  output logic [IdxW-1:0]   idx_o
);

  logic [IdxW-1:0] enc;

  // OR together the positions of set bits, then squash anything not one-hot.
  always_comb begin
    enc = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (onehot_i[i]) begin
        enc = enc | IdxW'(i);
      end
    end
    idx_o = is_onehot(onehot_i) ? enc : '0;
  end

endmodule

// File: rtl/rr_arbiter_16.sv
// 16-way round-robin arbiter with grant hold limit and timeout pulse.
module rr_arbiter_16
  import rr_arbiter_16_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input logic           clk,
  input logic           rst_n,
  rr_arbiter_16_if.slave bus
);

  localparam int unsigned ShW = IdxW + 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [NumReq-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0]   gnt_idx_q, gnt_idx_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic              timeout_q, timeout_d;

  logic [NumReq-1:0] rot_req;
  logic [NumReq-1:0] rot_sel;
  logic [ShW-1:0]    rot_back_amt;
  logic [NumReq-1:0] winner;
  logic [IdxW-1:0]   winner_idx;
  logic              rel_normal;
  logic              rel_limit;

  // Circular scan: rotate so ptr lands at bit 0, pick lowest set bit, rotate back.
  always_comb begin
    rot_req      = NumReq'({bus.req, bus.req} >> ptr_q);
    rot_sel      = rot_req & (~rot_req + NumReq'(1));
    rot_back_amt = ShW'(NumReq) - {1'b0, ptr_q};
    winner       = NumReq'({rot_sel, rot_sel} >> rot_back_amt);
  end

  onehot_idx16 u_onehot_idx16 (
    .onehot_i (winner),
    .idx_o    (winner_idx)
  );

  // Next-state and registered-output logic for the IDLE/GRANT FSM.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    rel_normal  = bus.done || !bus.req[gnt_idx_q];
    rel_limit   = (hold_q == HoldLast);

    case (state_q)
      StIdle: begin
        hold_d      = '0;
        gnt_d       = '0;
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
        if (bus.enable && (bus.req != '0)) begin
          state_d     = StGrant;
          gnt_d       = winner;
          gnt_idx_d   = winner_idx;
          gnt_valid_d = 1'b1;
        end
      end
      StGrant: begin
        if (rel_normal || rel_limit) begin
          state_d     = StIdle;
          hold_d      = '0;
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + IdxW'(1);
          // A coincident done/req drop wins over the hold limit.
          timeout_d   = rel_limit && !rel_normal;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      default: begin
        state_d     = StIdle;
        gnt_d       = '0;
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      hold_q      <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed self-checking bench for rr_arbiter_16 (default and MAX_HOLD=4 instances).
module tb_rr_arbiter_16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   cnt;

  rr_arbiter_16_if bus ();
  rr_arbiter_16_if bus4 ();

  rr_arbiter_16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  rr_arbiter_16 #(.MAX_HOLD(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input int idx);
    logic [15:0] oh;
    oh = 16'h0001 << idx;
    check_eq({tag, ".valid"}, 32'(bus.gnt_valid), 32'd1);
    check_eq({tag, ".idx"}, 32'(bus.gnt_idx), 32'(idx));
    check_eq({tag, ".gnt"}, 32'(bus.gnt), 32'(oh));
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".valid"}, 32'(bus.gnt_valid), 32'd0);
    check_eq({tag, ".gnt"}, 32'(bus.gnt), 32'd0);
    check_eq({tag, ".idx"}, 32'(bus.gnt_idx), 32'd0);
    check_eq({tag, ".tmo"}, 32'(bus.timeout), 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.enable = 1'b0;  bus.req = '0;  bus.done = 1'b0;
    bus4.enable = 1'b0; bus4.req = '0; bus4.done = 1'b0;
    #12;
    check_idle("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single requester 5, done release, then ptr=6 picks 6 over 5.
    bus.req = 16'h0020; bus.enable = 1'b1;
    tick();
    check_grant("r5", 5);
    bus.done = 1'b1;
    tick();
    check_idle("r5_rel");
    bus.done = 1'b0; bus.req = 16'h0060;
    tick();
    check_grant("ptr6", 6);
    bus.req = 16'h0000;
    tick();
    check_idle("drop6");

    // Reset back to ptr=0, then full sweep with bubbles.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    bus.req = 16'hFFFF;
    for (int k = 0; k <= 16; k++) begin
      tick();
      check_grant($sformatf("sweep%0d", k), k % 16);
      bus.done = 1'b1;
      tick();
      check_eq($sformatf("sweep%0d.bubble", k), 32'(bus.gnt_valid), 32'd0);
      bus.done = 1'b0;
    end

    // Wrap-around: grant 14 moves ptr to 15, then 8001 grants 15 then 0.
    bus.req = 16'h4000;
    tick();
    check_grant("g14", 14);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0; bus.req = 16'h8001;
    tick();
    check_grant("wrap15", 15);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    check_grant("wrap0", 0);
    bus.req = 16'h0000;
    tick();
    check_idle("wrap_rel");

    // Enable dropped mid-grant keeps grant but blocks the next one.
    bus.req = 16'h0004;
    tick();
    check_grant("en_g2", 2);
    bus.enable = 1'b0; bus.req = 16'hFFFF;
    tick();
    check_grant("en_hold", 2);
    bus.done = 1'b1;
    tick();
    check_idle("en_rel");
    bus.done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("en_block%0d", k), 32'(bus.gnt_valid), 32'd0);
    end
    bus.req = 16'h0013; bus.enable = 1'b1;
    tick();
    check_grant("en_ptr3", 4);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;

    // Reset mid-grant clears outputs asynchronously; rescan starts at 0.
    bus.req = 16'h0100;
    tick();
    check_grant("pre_rst", 8);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.req = 16'h0300;
    tick();
    check_grant("post_rst", 8);
    bus.req = 16'h0000;
    tick();

    // Default hold limit: grant held 16 cycles, then timeout pulse.
    bus.req = 16'h0002;
    tick();
    check_grant("hold16", 1);
    cnt = 1;
    while (bus.gnt_valid && cnt < 40) begin
      tick();
      if (bus.gnt_valid) cnt++;
      else check_eq("hold16.tmo", 32'(bus.timeout), 32'd1);
    end
    check_eq("hold16.cycles", 32'(cnt), 32'd16);
    bus.req = 16'h0000;
    tick();
    check_eq("hold16.tmo_off", 32'(bus.timeout), 32'd0);

    // MAX_HOLD=4: four grant cycles, single timeout, ptr becomes 4.
    bus4.req = 16'h0008; bus4.enable = 1'b1;
    tick();
    check_eq("h4.idx", 32'(bus4.gnt_idx), 32'd3);
    for (int k = 1; k < 4; k++) begin
      tick();
      check_eq($sformatf("h4.valid%0d", k), 32'(bus4.gnt_valid), 32'd1);
      check_eq($sformatf("h4.tmo%0d", k), 32'(bus4.timeout), 32'd0);
    end
    tick();
    check_eq("h4.rel", 32'(bus4.gnt_valid), 32'd0);
    check_eq("h4.tmo", 32'(bus4.timeout), 32'd1);
    bus4.req = 16'h0018;
    tick();
    check_eq("h4.tmo_once", 32'(bus4.timeout), 32'd0);
    check_eq("h4.ptr4", 32'(bus4.gnt_idx), 32'd4);

    // Done coinciding with the hold limit is a normal release.
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("h4c.valid%0d", k), 32'(bus4.gnt_valid), 32'd1);
    end
    bus4.done = 1'b1;
    tick();
    check_eq("h4c.rel", 32'(bus4.gnt_valid), 32'd0);
    check_eq("h4c.tmo", 32'(bus4.timeout), 32'd0);
    bus4.done = 1'b0; bus4.req = 16'h0000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
